// File: rtl/sr_bank_driver_pkg.sv
// Shared definitions for the SR bank driver: FSM state encoding and default
// parameter values.
package sr_bank_driver_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_TIMEOUT = 3;
    localparam int unsigned DEF_RETRIES = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } drv_state_e;

endpackage

// File: rtl/sr_excite.sv
// SR excitation: per bit, set where the target is 1 and q is 0, reset where
// the target is 0 and q is 1, hold (00) where they already match. s and r are
// never both asserted on the same bit.
//   tgt  in   WIDTH  target q value
//   q    in   WIDTH  current q of the bank
//   s_c  out  WIDTH  set excitation (combinational)
//   r_c  out  WIDTH  reset excitation (combinational)
module sr_excite
    import sr_bank_driver_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] s_c,
    output logic [WIDTH-1:0] r_c
);

    always_comb begin
        s_c = tgt & ~q;
        r_c = ~tgt & q;
    end

endmodule

// File: rtl/sr_bank_driver.sv
// Initiator for a WIDTH-bit bank of SR flip-flops. Accepts a target word,
// drives one cycle of s/r excitation, then watches q/nq feedback until the
// bank matches (done) or the wait/retry budget runs out (err).
//   clk        in   1      rising-edge clock, shared with the bank
//   cl_n       in   1      asynchronous active-low reset
//   req_valid  in   1      target word present
//   req_ready  out  1      driver idle, can accept
//   req_data   in   WIDTH  target q value
//   s, r       out  WIDTH  set/reset lines to the bank
//   q_fb       in   WIDTH  bank q feedback
//   nq_fb      in   WIDTH  bank nq feedback
//   busy       out  1      transaction in progress
//   done       out  1      one-cycle pulse: bank matches target
//   err        out  1      one-cycle pulse: retries exhausted
//   err_bits   out  WIDTH  target ^ q_fb at failure, held until next accept
module sr_bank_driver
    import sr_bank_driver_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned RETRIES = DEF_RETRIES
) (
    input  logic             clk,
    input  logic             cl_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q_fb,
    input  logic [WIDTH-1:0] nq_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);

    localparam int unsigned WCW = $clog2(TIMEOUT) + 1;
    localparam int unsigned ACW = $clog2(RETRIES + 1) + 1;

    drv_state_e       state, state_nxt;
    logic [WIDTH-1:0] tgt, tgt_nxt;
    logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
    logic [ACW-1:0]   attempt, attempt_nxt;
    logic [WIDTH-1:0] s_nxt, r_nxt, err_bits_nxt;
    logic             busy_nxt, done_nxt, err_nxt, ready_nxt;

    logic [WIDTH-1:0] exc_tgt_c, exc_s_c, exc_r_c;
    logic             match_c;

    // In IDLE the excitation is formed from the incoming word so s/r are
    // registered on the accept edge; on a retry the latched target is used.
    assign exc_tgt_c = (state == IDLE) ? req_data : tgt;

    sr_excite #(.WIDTH(WIDTH)) u_excite (
        .tgt (exc_tgt_c),
        .q   (q_fb),
        .s_c (exc_s_c),
        .r_c (exc_r_c)
    );

    // Settled only when both rails agree with the target; q==nq on any bit
    // fails one of the two compares.
    assign match_c = (q_fb == tgt) && (nq_fb == ~tgt);

    // State and output registers
    always_ff @(posedge clk or negedge cl_n) begin
        if (!cl_n) begin
            state     <= IDLE;
            tgt       <= '0;
            wait_cnt  <= '0;
            attempt   <= '0;
            s         <= '0;
            r         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
            err_bits  <= '0;
        end else begin
            state     <= state_nxt;
            tgt       <= tgt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            attempt   <= attempt_nxt;
            s         <= s_nxt;
            r         <= r_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            req_ready <= ready_nxt;
            err_bits  <= err_bits_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        tgt_nxt      = tgt;
        wait_cnt_nxt = wait_cnt;
        attempt_nxt  = attempt;
        s_nxt        = '0;
        r_nxt        = '0;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        ready_nxt    = req_ready;
        err_bits_nxt = err_bits;

        unique case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
                if (req_valid && req_ready) begin
                    tgt_nxt      = req_data;
                    wait_cnt_nxt = '0;
                    attempt_nxt  = '0;
                    s_nxt        = exc_s_c;
                    r_nxt        = exc_r_c;
                    busy_nxt     = 1'b1;
                    ready_nxt    = 1'b0;
                    err_bits_nxt = '0;
                    state_nxt    = DRIVE;
                end
            end

            DRIVE: begin
                wait_cnt_nxt = '0;
                state_nxt    = WAIT;
            end

            WAIT: begin
                if (match_c) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt < WCW'(TIMEOUT - 1)) begin
                    wait_cnt_nxt = wait_cnt + WCW'(1);
                end else if (attempt < ACW'(RETRIES)) begin
                    attempt_nxt  = attempt + ACW'(1);
                    wait_cnt_nxt = '0;
                    s_nxt        = exc_s_c;
                    r_nxt        = exc_r_c;
                    state_nxt    = DRIVE;
                end else begin
                    err_nxt      = 1'b1;
                    err_bits_nxt = tgt ^ q_fb;
                    busy_nxt     = 1'b0;
                    ready_nxt    = 1'b1;
                    state_nxt    = IDLE;
                end
            end

            default: begin
                busy_nxt  = 1'b0;
                ready_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver with a behavioural 4-cell SR bank as the load.
module tb_sr_bank_driver;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned TIMEOUT = 3;
    localparam int unsigned RETRIES = 1;

    logic             clk = 1'b0;
    logic             cl_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [WIDTH-1:0] s, r, q_fb, nq_fb, err_bits;
    logic             busy, done, err;

    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] stuck_lo;
    logic             bank_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_bank_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .RETRIES(RETRIES)) dut (
        .clk       (clk),
        .cl_n      (cl_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .nq_fb     (nq_fb),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_bits  (err_bits)
    );

    // Four SR cells; stuck_lo forces the q feedback of selected bits to 0
    always @(posedge clk) begin
        if (bank_clr) bank_q <= '0;
        else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({s[i], r[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= 1'bx;
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end
    assign q_fb  = bank_q & ~stuck_lo;
    assign nq_fb = ~q_fb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) check_eq("sr_excl", 32'(s & r), 32'd0);

    typedef struct {
        logic [WIDTH-1:0] s0, r0, s1, r1;
        bit               retry;
        bit               ok;
        int               end_c;
        logic [WIDTH-1:0] ebits;
        logic [WIDTH-1:0] q_after;
    } exp_t;

    // Outcome of one request: drive attempts against the bank as it evolves,
    // interval index (0 = cycle after accept) of the done/err pulse.
    function automatic exp_t model(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] bank,
                                   input logic [WIDTH-1:0] stuck);
        exp_t e;
        logic [WIDTH-1:0] ib, qo, sv, rv;
        ib = bank;
        qo = bank & ~stuck;
        e.ok = 0; e.retry = 0; e.s0 = 0; e.r0 = 0; e.s1 = 0; e.r1 = 0; e.end_c = 0;
        for (int a = 0; a <= int'(RETRIES); a++) begin
            qo = ib & ~stuck;
            sv = tgt & ~qo;
            rv = ~tgt & qo;
            if (a == 0) begin e.s0 = sv; e.r0 = rv; end
            else begin e.s1 = sv; e.r1 = rv; e.retry = 1; end
            ib = (ib | sv) & ~rv;
            qo = ib & ~stuck;
            if (qo == tgt) begin
                e.ok = 1;
                e.end_c = a * int'(TIMEOUT + 1) + 2;
                break;
            end
        end
        if (!e.ok) begin
            e.end_c = int'((RETRIES + 1) * (TIMEOUT + 1));
            e.ebits = tgt ^ qo;
        end else begin
            e.ebits = '0;
        end
        e.q_after = qo;
        return e;
    endfunction

    task automatic wait_ready(input string name);
        int t = 0;
        while (req_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq({name, "_ready"}, 32'(req_ready), 32'd1);
    endtask

    // One request from a negedge; ends on a negedge
    task automatic run_txn(input string name, input logic [WIDTH-1:0] tgt,
                           input logic [WIDTH-1:0] stuck);
        exp_t e;
        int   got_end;
        logic [WIDTH-1:0] exp_s, exp_r;
        stuck_lo = stuck;
        wait_ready(name);
        e = model(tgt, bank_q, stuck);
        req_valid = 1'b1;
        req_data  = tgt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = WIDTH'($urandom);
        got_end   = -1;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            exp_s = '0;
            exp_r = '0;
            if (c == 0) begin
                exp_s = e.s0; exp_r = e.r0;
                check_eq({name, "_busy"}, 32'(busy), 32'd1);
                check_eq({name, "_ready_busy"}, 32'(req_ready), 32'd0);
                check_eq({name, "_ebits_clr"}, 32'(err_bits), 32'd0);
            end else if (e.retry && c == int'(TIMEOUT + 1)) begin
                exp_s = e.s1; exp_r = e.r1;
            end
            if (c == 0 || (e.retry && c == int'(TIMEOUT + 1)) || s != 0 || r != 0)
                check_eq({name, "_sr"}, 32'({s, r}), 32'({exp_s, exp_r}));
            if (done || err) begin
                got_end = c;
                break;
            end
        end
        check_eq({name, "_end_cycle"}, 32'(got_end), 32'(e.end_c));
        check_eq({name, "_done"}, 32'(done), 32'(e.ok));
        check_eq({name, "_err"}, 32'(err), 32'(!e.ok));
        check_eq({name, "_ready_end"}, 32'(req_ready), 32'd1);
        check_eq({name, "_busy_end"}, 32'(busy), 32'd0);
        check_eq({name, "_err_bits"}, 32'(err_bits), 32'(e.ebits));
        @(negedge clk);
        check_eq({name, "_pulse_1cyc"}, 32'({done, err}), 32'd0);
        check_eq({name, "_ebits_hold"}, 32'(err_bits), 32'(e.ebits));
        check_eq({name, "_q"}, 32'(q_fb), 32'(e.q_after));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, n_done;
        logic [WIDTH-1:0] t, st;

        // 1: reset
        cl_n = 1'b0; bank_clr = 1'b1; stuck_lo = '0;
        req_valid = 1'b0; req_data = '0;
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_outs", 32'({s, r, busy, done, err, req_ready, err_bits}), 32'd0);
        end
        cl_n = 1'b1; bank_clr = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_ready_after", 32'(req_ready), 32'd1);
        @(negedge clk);

        // 2-4: directed requests, last one with q_fb[0] stuck low
        run_txn("t2", 4'b1010, 4'b0000);
        check_eq("t2_nq", 32'(nq_fb), 32'(4'b0101));
        run_txn("t3", 4'b0110, 4'b0000);
        run_txn("t4", 4'b0001, 4'b0001);

        // 5: back-to-back with req_valid held
        stuck_lo = '0;
        @(negedge clk);
        wait_ready("b2b");
        req_valid = 1'b1;
        req_data  = 4'b1111;
        n_acc = 0;
        n_done = 0;
        for (int k = 0; k < 16; k++) begin
            if (req_valid && req_ready) begin
                if (n_acc == 1) check_eq("b2b_acc_on_done", 32'(done), 32'd1);
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc == 1) req_data = 4'b0000;
                else            req_valid = 1'b0;
            end else begin
                @(posedge clk);
            end
            @(negedge clk);
            if (done) n_done++;
        end
        req_valid = 1'b0;
        check_eq("b2b_accepts", 32'(n_acc), 32'd2);
        check_eq("b2b_dones", 32'(n_done), 32'd2);
        check_eq("b2b_q", 32'(q_fb), 32'd0);

        // 6: reset during WAIT
        wait_ready("rstw");
        req_valid = 1'b1;
        req_data  = 4'b0101;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstw_busy_pre", 32'(busy), 32'd1);
        #2;
        cl_n = 1'b0;
        #1;
        check_eq("rstw_async", 32'({s, r, busy, req_ready}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_eq("rstw_no_pulse", 32'({done, err}), 32'd0);
        end
        cl_n = 1'b1;
        run_txn("rstw_after", 4'b0101, 4'b0000);

        // Random requests, occasionally with stuck-low feedback bits
        for (int n = 0; n < 24; n++) begin
            t  = WIDTH'($urandom_range(0, 15));
            st = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(1, 15)) : '0;
            run_txn("rnd", t, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
